// File: rtl/bpm_test_link_checker_if.sv
// ---------------------------------------------------------------------------
// bpm_test_link_checker_if
//   Receive-side AXI stream bundle of the BPM test link as it comes out of
//   the Aurora core. The stream has no tready: every valid beat is accepted.
//
//   tdata   32  stream data
//   tvalid  1   beat valid
//   tlast   1   last beat of packet
//
//   master : drives the stream (Aurora core or a testbench)
//   slave  : consumes the stream (the checker)
// ---------------------------------------------------------------------------
interface bpm_test_link_checker_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;

  modport master (output tdata, tvalid, tlast);
  modport slave  (input  tdata, tvalid, tlast);
endinterface

// File: rtl/bpm_test_link_checker.sv
// ---------------------------------------------------------------------------
// bpm_test_link_checker
//   Receive-side checker for the BPM test link. It walks each packet on the
//   Aurora RX stream and validates the header magic, the payload pattern,
//   the packet length and the sequence number. Status counters report good
//   packets, bad packets, packets that arrive out of sequence, and FA
//   windows in which no packet completed.
//
//   Packet layout (PACKET_WORDS beats, tlast on the final beat only):
//     word 0 : {MAGIC, seq}
//     word i : {seq, i}            i = 1 .. PACKET_WORDS-1
//
// Ports
//   auroraUserClk           in   sole clock
//   auroraReset_n           in   asynchronous active-low reset
//   auroraFAstrobe          in   single-cycle FA strobe
//   BPM_TEST_AXI_STREAM_RX  if   RX stream (slave side, always accepted)
//   clearCounters           in   sync pulse: zero counters, resync sequence
//   goodCount               out  fully correct packets
//   badCount                out  magic / payload / length errors
//   seqErrCount             out  correct packets with unexpected sequence
//   missingCount            out  FA windows with no completed packet
//   lastSeq                 out  sequence field of the last good packet
//   errorStrobe             out  1-cycle pulse on a bad or seq-error packet
//
// All status outputs are registered and reflect the beat that decided the
// packet one clock later. Counters saturate at all-ones.
// ---------------------------------------------------------------------------
//   state       | meaning
//   ------------+--------------------------------------------------------
//   ST_HEADER   | waiting for word 0; checks magic
//   ST_PAYLOAD  | checking words 1..N-1 against {seq, idx}
//   ST_DISCARD  | packet already judged bad; drop beats until tlast
// ---------------------------------------------------------------------------
module bpm_test_link_checker #(
  parameter int          PACKET_WORDS = 4,
  parameter logic [15:0] MAGIC        = 16'hB5A7,
  parameter int          CNT_WIDTH    = 16
) (
  input  logic                          auroraUserClk,
  input  logic                          auroraReset_n,
  input  logic                          auroraFAstrobe,
  bpm_test_link_checker_if.slave        BPM_TEST_AXI_STREAM_RX,
  input  logic                          clearCounters,
  output logic [CNT_WIDTH-1:0]          goodCount,
  output logic [CNT_WIDTH-1:0]          badCount,
  output logic [CNT_WIDTH-1:0]          seqErrCount,
  output logic [CNT_WIDTH-1:0]          missingCount,
  output logic [15:0]                   lastSeq,
  output logic                          errorStrobe
);

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef enum logic [1:0] {
    ST_HEADER  = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(PACKET_WORDS - 1);

  // stream aliases
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_last;

  assign rx_data  = BPM_TEST_AXI_STREAM_RX.tdata;
  assign rx_valid = BPM_TEST_AXI_STREAM_RX.tvalid;
  assign rx_last  = BPM_TEST_AXI_STREAM_RX.tlast;

  // packet parser state
  state_t      state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] idx_q, idx_d;
  logic        mism_q, mism_d;

  // per-beat verdicts from the parser
  logic        pkt_good;
  logic        pkt_bad;
  logic        payload_err;

  // sequence tracking and FA window bookkeeping
  logic [15:0] expected_q;
  logic        resync_q;
  logic        armed_q;
  logic        seen_q;

  logic        seq_match;
  logic        good_evt;
  logic        seqerr_evt;
  logic        pkt_done;
  logic        missing_evt;

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Parser: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge auroraUserClk or negedge auroraReset_n) begin
    if (!auroraReset_n) begin
      state_q <= ST_HEADER;
      seq_q   <= '0;
      idx_q   <= '0;
      mism_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      mism_q  <= mism_d;
    end
  end

  // -------------------------------------------------------------------------
  // Parser: next state and per-beat verdict. Only valid beats advance it,
  // so gaps inside a packet leave idx and the mismatch flag untouched.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    idx_d       = idx_q;
    mism_d      = mism_q;
    pkt_good    = 1'b0;
    pkt_bad     = 1'b0;
    // A payload mismatch is remembered but only counted once the packet
    // ends, so a corrupted packet still contributes exactly one bad count.
    payload_err = mism_q | (rx_data != {seq_q, idx_q});

    if (rx_valid) begin
      case (state_q)
        ST_HEADER: begin
          if (rx_data[31:16] != MAGIC) begin
            pkt_bad = 1'b1;
            state_d = rx_last ? ST_HEADER : ST_DISCARD;
          end else if (rx_last) begin
            pkt_bad = 1'b1;
            state_d = ST_HEADER;
          end else begin
            seq_d   = rx_data[15:0];
            idx_d   = 16'd1;
            mism_d  = 1'b0;
            state_d = ST_PAYLOAD;
          end
        end

        ST_PAYLOAD: begin
          // idx never exceeds LAST_IDX here, so "!=" means "short".
          if (rx_last && (idx_q != LAST_IDX)) begin
            pkt_bad = 1'b1;
            state_d = ST_HEADER;
          end else if ((idx_q == LAST_IDX) && !rx_last) begin
            pkt_bad = 1'b1;
            state_d = ST_DISCARD;
          end else if (idx_q == LAST_IDX) begin
            pkt_bad  = payload_err;
            pkt_good = !payload_err;
            state_d  = ST_HEADER;
          end else begin
            idx_d  = idx_q + 16'd1;
            mism_d = payload_err;
          end
        end

        ST_DISCARD: begin
          if (rx_last) begin
            state_d = ST_HEADER;
          end
        end

        default: begin
          state_d = ST_HEADER;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Packet classification against the sequence tracker
  // -------------------------------------------------------------------------
  assign seq_match   = resync_q || (seq_q == expected_q);
  assign good_evt    = pkt_good && seq_match;
  assign seqerr_evt  = pkt_good && !seq_match;
  assign pkt_done    = pkt_good || pkt_bad;
  // A packet finishing on the strobe cycle still belongs to the window
  // that the strobe closes.
  assign missing_evt = auroraFAstrobe && armed_q && !(seen_q || pkt_done);

  // -------------------------------------------------------------------------
  // Status registers
  // -------------------------------------------------------------------------
  always_ff @(posedge auroraUserClk or negedge auroraReset_n) begin
    if (!auroraReset_n) begin
      goodCount    <= '0;
      badCount     <= '0;
      seqErrCount  <= '0;
      missingCount <= '0;
      lastSeq      <= '0;
      errorStrobe  <= 1'b0;
      expected_q   <= '0;
      resync_q     <= 1'b1;
      armed_q      <= 1'b0;
      seen_q       <= 1'b0;
    end else begin
      errorStrobe <= pkt_bad || seqerr_evt;

      if (pkt_good) begin
        lastSeq    <= seq_q;
        expected_q <= seq_q + 16'd1;
      end

      if (clearCounters) begin
        goodCount    <= '0;
        badCount     <= '0;
        seqErrCount  <= '0;
        missingCount <= '0;
        resync_q     <= 1'b1;
        armed_q      <= 1'b0;
        seen_q       <= 1'b0;
      end else begin
        if (good_evt) begin
          goodCount <= sat_inc(goodCount);
        end
        if (seqerr_evt) begin
          seqErrCount <= sat_inc(seqErrCount);
        end
        if (pkt_bad) begin
          badCount <= sat_inc(badCount);
        end
        if (missing_evt) begin
          missingCount <= sat_inc(missingCount);
        end
        if (pkt_good) begin
          resync_q <= 1'b0;
        end
        if (auroraFAstrobe) begin
          seen_q  <= 1'b0;
          armed_q <= 1'b1;
        end else if (pkt_done) begin
          seen_q <= 1'b1;
        end
      end
    end
  end

endmodule
